adc_capture_packer: RTL and testbench

//  Multi-channel successor to the per-channel ADC DDR demux stage. Sits after the IDDR2 receivers in the clk64 domain.

---
 rtl/adc_capture_packer.sv | 163 ++++++++++++++++
 tb/tb_adc_capture_packer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_packer.sv
// Multi-channel ADC capture: decimated, masked captures into a FIFO,
// serialised as one word per enabled channel on a valid/ready stream.
module adc_capture_packer #(
  parameter int NCH   = 4,
  parameter int SW    = 8,
  parameter int DEPTH = 16,
  parameter int CHW   = 2
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [NCH*2*SW-1:0]      din,
  input  logic [NCH-1:0]           ch_en,
  input  logic                     run,
  input  logic [7:0]               decim,
  output logic [2*SW-1:0]          out_data,
  output logic [CHW-1:0]           out_chan,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int CW = 2 * SW;
  localparam int AW = $clog2(DEPTH);
  localparam int DW = NCH * CW;
  localparam int EW = NCH + DW;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_n;
  logic [EW-1:0]  mem [DEPTH];
  logic [AW:0]    wptr, rptr;
  logic [7:0]     dcnt;
  logic           run_q;
  logic           cap, full, empty, wr, drop, pop;
  logic [EW-1:0]  head;
  logic [NCH-1:0] hm, rem, rem_n;
  logic [DW-1:0]  hd, sh_data, sh_n;
  logic [CHW-1:0] hidx, ridx, oc_n;
  logic [CW-1:0]  hword, rword, od_n;

  assign fifo_level = wptr - rptr;
  assign empty      = (wptr == rptr);
  assign full       = (fifo_level == (AW+1)'(DEPTH));
  assign cap        = run && (dcnt == 8'd0) && (ch_en != '0);
  assign wr         = cap && !full;
  assign drop       = cap && full;

  assign head = mem[rptr[AW-1:0]];
  assign hm   = head[EW-1 -: NCH];
  assign hd   = head[DW-1:0];

  assign out_valid = (state == SEND);
  assign out_last  = (state == SEND) && (rem == '0);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= {ch_en, din};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr  <= '0;
      rptr  <= '0;
      dcnt  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= run;
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (!run)              dcnt <= '0;
      else if (dcnt == '0)   dcnt <= decim;
      else                   dcnt <= dcnt - 1'b1;
    end
  end

  // A drop on the run rising edge counts on top of the cleared value.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (run && !run_q) begin
      overflow   <= drop;
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

  always_comb begin
    hidx  = '0;
    hword = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (hm[c]) begin
        hidx  = CHW'(c);
        hword = hd[c*CW +: CW];
      end
    end
  end

  always_comb begin
    ridx  = '0;
    rword = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (rem[c]) begin
        ridx  = CHW'(c);
        rword = sh_data[c*CW +: CW];
      end
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem;
    sh_n    = sh_data;
    od_n    = out_data;
    oc_n    = out_chan;
    pop     = 1'b0;
    unique case (state)
      IDLE: pop = !empty;
      SEND: begin
        if (out_ready) begin
          if (!out_last) begin
            oc_n  = ridx;
            od_n  = rword;
            rem_n = rem & (rem - 1'b1);
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (pop) begin
      state_n = SEND;
      sh_n    = hd;
      oc_n    = hidx;
      od_n    = hword;
      rem_n   = hm & (hm - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      rem      <= '0;
      sh_data  <= '0;
      out_data <= '0;
      out_chan <= '0;
    end else begin
      state    <= state_n;
      rem      <= rem_n;
      sh_data  <= sh_n;
      out_data <= od_n;
      out_chan <= oc_n;
    end
  end

endmodule

// File: tb/tb_adc_capture_packer.sv
// Bench for adc_capture_packer: directed cases plus random traffic
// checked against a queue-based capture/stream model.
module tb_adc_capture_packer;

  localparam int NCH = 4;
  localparam int SW = 8;
  localparam int DEPTH = 16;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic nreset;
  logic [NCH*2*SW-1:0] din;
  logic [NCH-1:0] ch_en;
  logic run;
  logic [7:0] decim;
  logic [2*SW-1:0] out_data;
  logic [CHW-1:0] out_chan;
  logic out_last, out_valid, out_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic overflow;
  logic [15:0] drop_count;

  adc_capture_packer #(
    .NCH(NCH), .SW(SW), .DEPTH(DEPTH), .CHW(CHW)
  ) dut (
    .clk(clk), .nreset(nreset), .din(din), .ch_en(ch_en),
    .run(run), .decim(decim), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  c;
    logic        l;
  } word_t;
  typedef struct {
    logic [3:0]  m;
    logic [63:0] d;
  } ent_t;

  ent_t  q[$];
  word_t cur[$];
  int    k;
  bit    prev_run;
  bit    m_ovf;
  int    m_dc;
  int    nchk = 0;
  int    npass = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void expand(input ent_t e);
    word_t w;
    for (int c = 0; c < NCH; c++) begin
      if (e.m[c]) begin
        w.d = e.d[c*16 +: 16];
        w.c = 2'(c);
        w.l = ((e.m >> (c + 1)) == 4'd0);
        cur.push_back(w);
      end
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    cur.delete();
    k = 0;
    prev_run = 1'b0;
    m_ovf = 1'b0;
    m_dc = 0;
  endfunction

  // Capture slots fall every decim+1 cycles counted from the run rising edge.
  function automatic void model_step();
    bit rise, cap, drop;
    int qs;
    ent_t e;
    rise = run && !prev_run;
    if (rise) k = 0;
    cap = run && (k % (int'(decim) + 1) == 0) && (ch_en != 4'd0);
    qs = q.size();
    if (cur.size() > 0 && out_ready) begin
      void'(cur.pop_front());
      if (cur.size() == 0 && qs > 0) expand(q.pop_front());
    end else if (cur.size() == 0 && qs > 0) begin
      expand(q.pop_front());
    end
    drop = cap && (qs == DEPTH);
    if (cap && !drop) begin
      e.m = ch_en;
      e.d = din;
      q.push_back(e);
    end
    if (rise) begin
      m_ovf = 1'b0;
      m_dc = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_dc < 65535) m_dc++;
    end
    if (run) k++;
    prev_run = run;
  endfunction

  task automatic check_all();
    check("valid", out_valid, cur.size() > 0);
    if (cur.size() > 0) begin
      check("data", out_data, cur[0].d);
      check("chan", out_chan, cur[0].c);
      check("last", out_last, cur[0].l);
    end
    check("level", fifo_level, q.size());
    check("overflow", overflow, m_ovf);
    check("drops", drop_count, m_dc);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  int words;
  int thr;

  initial begin
    nreset = 1'b0;
    din = '0;
    ch_en = '0;
    run = 1'b0;
    decim = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_data", out_data, 0);
    nreset = 1'b1;

    // T1: single 4-channel capture, two-edge latency.
    din = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    ch_en = 4'hF;
    out_ready = 1'b1;
    run = 1'b1;
    step();
    run = 1'b0;
    check("t1_lat0", out_valid, 1'b0);
    step();
    check("t1_w0", {out_valid, out_data, 2'(out_chan), out_last},
          {1'b1, 16'h1111, 2'd0, 1'b0});
    step();
    step();
    step();
    check("t1_w3", {out_valid, out_data, 2'(out_chan), out_last},
          {1'b1, 16'h4444, 2'd3, 1'b1});
    step();
    check("t1_end", out_valid, 1'b0);

    // T2: sparse mask.
    ch_en = 4'b1010;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    check("t2_w0", {out_data, 2'(out_chan), out_last},
          {16'h2222, 2'd1, 1'b0});
    step();
    check("t2_w1", {out_data, 2'(out_chan), out_last},
          {16'h4444, 2'd3, 1'b1});
    step();
    check("t2_end", out_valid, 1'b0);

    // T3: stall until full; one capture sits in the serialiser.
    ch_en = 4'hF;
    out_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = {$urandom, $urandom};
      step();
    end
    run = 1'b0;
    step();
    check("t3_level", fifo_level, DEPTH);
    check("t3_drops", drop_count, 20 - (DEPTH + 1));
    check("t3_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4 * (DEPTH + 1); i++) begin
      check("t3_nobubble", out_valid, 1'b1);
      step();
    end
    check("t3_drained", out_valid, 1'b0);
    run = 1'b1;
    step();
    run = 1'b0;
    check("t3_clr_ovf", overflow, 1'b0);
    check("t3_clr_drops", drop_count, 0);
    repeat (6) step();

    // T4: decimation 2 gives 3 captures in 9 cycles; masked-off slot skipped.
    decim = 8'd2;
    ch_en = 4'b0001;
    words = 0;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (out_valid) words++;
    end
    run = 1'b0;
    repeat (4) begin
      step();
      if (out_valid) words++;
    end
    check("t4_captures", words, 3);
    words = 0;
    run = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ch_en = (i == 3) ? 4'b0000 : 4'b0001;
      step();
      if (out_valid) words++;
    end
    run = 1'b0;
    repeat (4) begin
      step();
      if (out_valid) words++;
    end
    check("t4_masked", words, 2);
    check("t4_drops", drop_count, 0);
    decim = 8'd0;

    // T5: toggling ready.
    ch_en = 4'hF;
    din = {$urandom, $urandom};
    run = 1'b1;
    step();
    run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();

    // T6: async reset mid-SEND with entries queued.
    out_ready = 1'b0;
    run = 1'b1;
    repeat (4) begin
      din = {$urandom, $urandom};
      step();
    end
    run = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("t6_pre_level", fifo_level, 3);
    #2 nreset = 1'b0;
    #1;
    check("t6_valid", out_valid, 1'b0);
    check("t6_level", fifo_level, 0);
    check("t6_outs", {out_data, 2'(out_chan), out_last, overflow},
          {16'h0, 2'd0, 1'b0, 1'b0});
    check("t6_drops", drop_count, 0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    din = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    ch_en = 4'hF;
    run = 1'b1;
    step();
    run = 1'b0;
    check("t6_lat0", out_valid, 1'b0);
    step();
    check("t6_w0", {out_valid, out_data, 2'(out_chan)},
          {1'b1, 16'h1111, 2'd0});
    repeat (4) step();

    // Random traffic; run only rises when a drop cannot coincide.
    thr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) thr = $urandom_range(10, 100);
      out_ready = ($urandom_range(0, 99) < thr);
      ch_en = 4'($urandom_range(0, 15));
      din = {$urandom, $urandom};
      if (!run) begin
        if ($urandom_range(0, 7) == 0 && q.size() < DEPTH) begin
          decim = 8'($urandom_range(0, 3));
          run = 1'b1;
        end
      end else if ($urandom_range(0, 39) == 0) begin
        run = 1'b0;
      end
      step();
    end
    run = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (cur.size() > 0 || q.size() > 0); i++)
      step();
    check("drain_done", cur.size() + q.size(), 0);
    check("drain_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
